alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station that feeds the integer ALU in the out-of-order core. It accepts decoded ALU instructions from dispatch, holds them until both operands are available, and snoops two common data buses (ALU result bus and load/store result bus) for pending operands. Each cycle it issues at most one ready instruction to the ALU on the `cal`/`a`/`b`/`alu_op` interface, tagged with its ROB index.

## Interface
Parameters:
- `RS_WIDTH`, 3: log2 of entry count; `RS_SIZE = 1 << RS_WIDTH` (8 entries).
- `ROB_WIDTH`, 4: ROB tag width.

Ports:
- `clk_in`  in  1  clock; one clock, all state on rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  global ready; low means the CPU is stalled.
- `clear`  in  1  flush on mispredict; acted on only when `rdy_in` is high.
- `in_valid`  in  1  dispatch request.
- `in_op`  in  4  ALU opcode (ADD 0000 … SLTU 1001).
- `in_qj_busy`, `in_qk_busy`  in  1  operand j/k pending on a ROB tag.
- `in_qj`, `in_qk`  in  ROB_WIDTH  producer tags.
- `in_vj`, `in_vk`  in  32  operand values, valid when the matching busy bit is 0.
- `in_dest`  in  ROB_WIDTH  destination ROB tag.
- `full`  out  1  combinational; high when all entries are busy.
- `cdb0_valid`, `cdb1_valid`  in  1  result broadcast valid (0 = ALU, 1 = LSB).
- `cdb0_tag`, `cdb1_tag`  in  ROB_WIDTH  broadcast tag.
- `cdb0_val`, `cdb1_val`  in  32  broadcast value.
- `cal`  out  1  registered; issue strobe to the ALU.
- `a`, `b`  out  32  registered operands (j→a, k→b).
- `alu_op`  out  4  registered opcode.
- `out_dest`  out  ROB_WIDTH  registered ROB tag of the issued instruction.

## Operation
- Per entry: `busy`, `op`, `qj_busy`/`qj`/`vj`, `qk_busy`/`qk`/`vk`, `dest`. A busy entry is ready when `!qj_busy && !qk_busy`.
- Dispatch: when `in_valid && !full`, write the lowest-index non-busy entry and set its busy bit. Dispatch while `full` is ignored and no entry changes.
- Dispatch-time forwarding: if an incoming operand is pending and a valid CDB carries the same tag in the same cycle, store the CDB value and clear that operand's busy bit. cdb0 wins if both buses match the same tag; this case is illegal in practice.
- Wakeup: each busy entry with a pending operand whose tag matches a valid CDB captures the value and clears that operand's busy bit. Both operands of one entry can wake in the same cycle from different buses.
- Select: pick the lowest-index entry that is ready in the state registered at the start of the cycle. On the edge, set `cal<=1` and load `a`, `b`, `alu_op`, `out_dest`, then clear that entry's busy bit. With no ready entry, `cal<=0` and `a`/`b`/`alu_op`/`out_dest` hold.
- `full` = (busy count == RS_SIZE), computed from registered state. An entry freed by issue in a cycle cannot take a dispatch in that same cycle.

## Timing
- Reset (`rst_in`=1 at an edge): all busy bits 0; `cal`=0; `a`=`b`=0; `alu_op`=0; `out_dest`=0; `full`=0. Reset overrides everything, including reset in the middle of a pending wakeup.
- `clear` with `rdy_in`=1: same effect as reset. Priority is reset > clear > normal operation.
- `rdy_in`=0 and no reset: no dispatch, wakeup or issue; entries hold; `cal<=0`. Producers do not broadcast while stalled.
- Dispatch latency: an instruction with both operands ready, dispatched at edge N, drives `cal`=1 after edge N+1.
- Wakeup latency: a CDB match at edge N makes the entry eligible for select in cycle N+1, so `cal` is high after edge N+1.
- Issue throughput is at most one per cycle; `cal` stays high on consecutive cycles while ready entries remain.
- Dispatch, wakeup and issue on different entries in the same cycle are all honoured.

## Test plan
- Reset, then dispatch ADD with vj=5, vk=7, dest=3 at edge 1 -> `cal`=1, `a`=5, `b`=7, `alu_op`=0000, `out_dest`=3 after edge 2; `cal`=0 after edge 3.
- Dispatch SUB with qj=6 pending, vk=1; cdb1 broadcasts tag 6, value 0x10 two cycles later -> issue exactly one cycle after the broadcast with `a`=0x10, `b`=1.
- Dispatch in_qj=2 while cdb0 broadcasts tag 2, value 9 in the same cycle -> entry stored as ready; issues next cycle with `a`=9.
- Fill all 8 entries with pending operands -> `full`=1, a 9th dispatch is dropped; broadcast one tag -> one issue, `full`=0 the cycle after the issue.
- Three ready entries at indices 1, 4, 6 -> issued on consecutive cycles in order 1, 4, 6.
- Entries pending, assert `clear` with `rdy_in`=1 -> all entries invalid, `cal`=0, and later broadcasts of the old tags cause no issue. Hold `rdy_in`=0 with a ready entry -> no issue until `rdy_in` returns high.

Source files
------------

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs : reservation station in front of the integer ALU.
//
// Holds up to RS_SIZE decoded ALU instructions until both operands are
// known. Pending operands are filled by snooping two result buses (cdb0
// from the ALU, cdb1 from the load/store buffer). At most one ready
// instruction is handed to the ALU per cycle, lowest entry index first.
//
// Ports
//   clk_in, rst_in     clock and synchronous active-high reset
//   rdy_in             global ready; low freezes the station
//   clear              mispredict flush, honoured only while rdy_in is high
//   in_valid ... in_dest
//                      dispatch request: opcode, two operands given either
//                      as a value (busy=0) or as a producer ROB tag (busy=1),
//                      and the destination ROB tag
//   full               combinational, every entry occupied
//   cdb0_*, cdb1_*     result broadcasts (valid, tag, value)
//   cal, a, b, alu_op, out_dest
//                      registered issue interface towards the ALU; the data
//                      outputs hold their last value while cal is low
// ---------------------------------------------------------------------------
module alu_rs #(
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,

    input  logic                 in_valid,
    input  logic [3:0]           in_op,
    input  logic                 in_qj_busy,
    input  logic                 in_qk_busy,
    input  logic [ROB_WIDTH-1:0] in_qj,
    input  logic [ROB_WIDTH-1:0] in_qk,
    input  logic [31:0]          in_vj,
    input  logic [31:0]          in_vk,
    input  logic [ROB_WIDTH-1:0] in_dest,
    output logic                 full,

    input  logic                 cdb0_valid,
    input  logic [ROB_WIDTH-1:0] cdb0_tag,
    input  logic [31:0]          cdb0_val,
    input  logic                 cdb1_valid,
    input  logic [ROB_WIDTH-1:0] cdb1_tag,
    input  logic [31:0]          cdb1_val,

    output logic                 cal,
    output logic [31:0]          a,
    output logic [31:0]          b,
    output logic [3:0]           alu_op,
    output logic [ROB_WIDTH-1:0] out_dest
);

    localparam int RS_SIZE = 1 << RS_WIDTH;

    // Entry storage. Only the busy flags need a reset value; the payload is
    // ignored while an entry is not busy.
    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   qj_busy;
    logic [RS_SIZE-1:0]   qk_busy;
    logic [3:0]           op   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk   [RS_SIZE];
    logic [31:0]          vj   [RS_SIZE];
    logic [31:0]          vk   [RS_SIZE];
    logic [ROB_WIDTH-1:0] dest [RS_SIZE];

    logic [RS_SIZE-1:0]   ready;
    logic                 free_found;
    logic [RS_WIDTH-1:0]  free_idx;
    logic                 issue_found;
    logic [RS_WIDTH-1:0]  issue_idx;
    logic                 dispatch_en;

    logic                 in_j_pending;
    logic                 in_k_pending;
    logic [31:0]          in_j_value;
    logic [31:0]          in_k_value;

    logic [RS_SIZE-1:0]   wake_j0;
    logic [RS_SIZE-1:0]   wake_j1;
    logic [RS_SIZE-1:0]   wake_k0;
    logic [RS_SIZE-1:0]   wake_k1;

    // Readiness and fullness come from registered state only, so a slot
    // freed by this cycle's issue is not reusable until the next cycle.
    assign ready       = busy & ~qj_busy & ~qk_busy;
    assign full        = &busy;
    assign dispatch_en = in_valid && !full && free_found;

    // Priority encoders: lowest free slot for dispatch, lowest ready slot
    // for issue. Scanning downward lets the lowest index win last.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = RS_WIDTH'(i);
            end
            if (ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = RS_WIDTH'(i);
            end
        end
    end

    // Dispatch-time forwarding: an operand whose producer broadcasts in the
    // same cycle is captured immediately. cdb0 is checked first.
    always_comb begin
        in_j_pending = in_qj_busy;
        in_j_value   = in_vj;
        if (in_qj_busy && cdb0_valid && (cdb0_tag == in_qj)) begin
            in_j_pending = 1'b0;
            in_j_value   = cdb0_val;
        end else if (in_qj_busy && cdb1_valid && (cdb1_tag == in_qj)) begin
            in_j_pending = 1'b0;
            in_j_value   = cdb1_val;
        end

        in_k_pending = in_qk_busy;
        in_k_value   = in_vk;
        if (in_qk_busy && cdb0_valid && (cdb0_tag == in_qk)) begin
            in_k_pending = 1'b0;
            in_k_value   = cdb0_val;
        end else if (in_qk_busy && cdb1_valid && (cdb1_tag == in_qk)) begin
            in_k_pending = 1'b0;
            in_k_value   = cdb1_val;
        end
    end

    // Per-entry wakeup matches. The cdb1 match is masked by a cdb0 match so
    // each operand has a single source even in the illegal double-match case.
    always_comb begin
        wake_j0 = '0;
        wake_j1 = '0;
        wake_k0 = '0;
        wake_k1 = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j0[i] = busy[i] && qj_busy[i] && cdb0_valid && (cdb0_tag == qj[i]);
            wake_j1[i] = busy[i] && qj_busy[i] && cdb1_valid && (cdb1_tag == qj[i])
                         && !wake_j0[i];
            wake_k0[i] = busy[i] && qk_busy[i] && cdb0_valid && (cdb0_tag == qk[i]);
            wake_k1[i] = busy[i] && qk_busy[i] && cdb1_valid && (cdb1_tag == qk[i])
                         && !wake_k0[i];
        end
    end

    // State update. Reset and an un-stalled flush empty the station and
    // zero the issue outputs; a stall freezes everything except dropping
    // cal. Otherwise wakeup, issue and dispatch all happen together; they
    // never touch the same entry because dispatch only targets a free slot
    // while wakeup and issue only act on occupied ones.
    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && clear)) begin
            busy     <= '0;
            qj_busy  <= '0;
            qk_busy  <= '0;
            cal      <= 1'b0;
            a        <= '0;
            b        <= '0;
            alu_op   <= '0;
            out_dest <= '0;
        end else if (!rdy_in) begin
            cal <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wake_j0[i]) begin
                    vj[i]      <= cdb0_val;
                    qj_busy[i] <= 1'b0;
                end else if (wake_j1[i]) begin
                    vj[i]      <= cdb1_val;
                    qj_busy[i] <= 1'b0;
                end
                if (wake_k0[i]) begin
                    vk[i]      <= cdb0_val;
                    qk_busy[i] <= 1'b0;
                end else if (wake_k1[i]) begin
                    vk[i]      <= cdb1_val;
                    qk_busy[i] <= 1'b0;
                end
            end

            if (issue_found) begin
                cal             <= 1'b1;
                a               <= vj[issue_idx];
                b               <= vk[issue_idx];
                alu_op          <= op[issue_idx];
                out_dest        <= dest[issue_idx];
                busy[issue_idx] <= 1'b0;
            end else begin
                cal <= 1'b0;
            end

            if (dispatch_en) begin
                busy[free_idx]    <= 1'b1;
                op[free_idx]      <= in_op;
                qj_busy[free_idx] <= in_j_pending;
                qj[free_idx]      <= in_qj;
                vj[free_idx]      <= in_j_value;
                qk_busy[free_idx] <= in_k_pending;
                qk[free_idx]      <= in_qk;
                vk[free_idx]      <= in_k_value;
                dest[free_idx]    <= in_dest;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs : self-checking bench for alu_rs.
// A table of hand-derived cycle vectors walks the directed scenarios, then a
// randomized run is checked against an entry-array reference model.
// ---------------------------------------------------------------------------
module tb_alu_rs;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        in_valid;
    logic [3:0]  in_op;
    logic        in_qj_busy, in_qk_busy;
    logic [3:0]  in_qj, in_qk;
    logic [31:0] in_vj, in_vk;
    logic [3:0]  in_dest;
    logic        full;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_val, cdb1_val;
    logic        cal;
    logic [31:0] a, b;
    logic [3:0]  alu_op;
    logic [3:0]  out_dest;

    int total = 0;
    int bad   = 0;

    alu_rs #(.RS_WIDTH(3), .ROB_WIDTH(4)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_op      (in_op),
        .in_qj_busy (in_qj_busy),
        .in_qk_busy (in_qk_busy),
        .in_qj      (in_qj),
        .in_qk      (in_qk),
        .in_vj      (in_vj),
        .in_vk      (in_vk),
        .in_dest    (in_dest),
        .full       (full),
        .cdb0_valid (cdb0_valid),
        .cdb0_tag   (cdb0_tag),
        .cdb0_val   (cdb0_val),
        .cdb1_valid (cdb1_valid),
        .cdb1_tag   (cdb1_tag),
        .cdb1_val   (cdb1_val),
        .cal        (cal),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .out_dest   (out_dest)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk_in = ~clk_in;

    // One cycle of inputs plus the outputs expected right after the edge.
    typedef struct {
        logic [31:0] rst, rdy, clr, vld, op;
        logic [31:0] qjb, qj, vj, qkb, qk, vk, dest;
        logic [31:0] c0v, c0t, c0d, c1v, c1t, c1d;
        logic [31:0] eCal, eA, eB, eOp, eDest, eFull;
    } vec_t;

    typedef struct {
        logic        busy;
        logic [3:0]  op;
        logic        jp;
        logic [3:0]  jt;
        logic [31:0] jv;
        logic        kp;
        logic [3:0]  kt;
        logic [31:0] kv;
        logic [3:0]  dest;
    } ent_t;

    // Reference model state
    ent_t        m [8];
    logic        mCal;
    logic [31:0] mA, mB;
    logic [3:0]  mOp, mDest;

    vec_t vecs[$];

    // Drive one cycle's worth of inputs
    task automatic applyStimulus(input vec_t v);
        rst_in     = v.rst[0];
        rdy_in     = v.rdy[0];
        clear      = v.clr[0];
        in_valid   = v.vld[0];
        in_op      = v.op[3:0];
        in_qj_busy = v.qjb[0];
        in_qj      = v.qj[3:0];
        in_vj      = v.vj;
        in_qk_busy = v.qkb[0];
        in_qk      = v.qk[3:0];
        in_vk      = v.vk;
        in_dest    = v.dest[3:0];
        cdb0_valid = v.c0v[0];
        cdb0_tag   = v.c0t[3:0];
        cdb0_val   = v.c0d;
        cdb1_valid = v.c1v[0];
        cdb1_tag   = v.c1t[3:0];
        cdb1_val   = v.c1d;
    endtask

    // Compare all DUT outputs against the expected set in one comparison
    task automatic checkOutput(input string name, input logic eCal, input logic [31:0] eA,
                               input logic [31:0] eB, input logic [3:0] eOp,
                               input logic [3:0] eDest, input logic eFull);
        total++;
        if (cal !== eCal || a !== eA || b !== eB || alu_op !== eOp ||
            out_dest !== eDest || full !== eFull) begin
            bad++;
            $display("[TB] FAIL %s got cal=%0b a=%h b=%h op=%0d dest=%0d full=%0b want cal=%0b a=%h b=%h op=%0d dest=%0d full=%0b",
                     name, cal, a, b, alu_op, out_dest, full,
                     eCal, eA, eB, eOp, eDest, eFull);
        end
    endtask

    // Resolve one operand against the buses: returns {still pending, value}
    function automatic logic [32:0] snoop(input vec_t v, input logic p,
                                          input logic [3:0] t, input logic [31:0] val);
        if (p && v.c0v[0] && v.c0t[3:0] == t) return {1'b0, v.c0d};
        if (p && v.c1v[0] && v.c1t[3:0] == t) return {1'b0, v.c1d};
        return {p, val};
    endfunction

    function automatic logic modelFull();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m[i].busy) n++;
        return (n == 8);
    endfunction

    // Advance the model by one clock edge with the given inputs
    task automatic modelStep(input vec_t v);
        ent_t        old [8];
        int          sel, freeSlot, used;
        logic [32:0] r;
        old = m;
        if (v.rst[0] || (v.rdy[0] && v.clr[0])) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            mCal = 0; mA = 0; mB = 0; mOp = 0; mDest = 0;
        end else if (!v.rdy[0]) begin
            mCal = 0;
        end else begin
            sel = -1; freeSlot = -1; used = 0;
            for (int i = 0; i < 8; i++) begin
                if (old[i].busy) used++;
                if (sel < 0 && old[i].busy && !old[i].jp && !old[i].kp) sel = i;
                if (freeSlot < 0 && !old[i].busy) freeSlot = i;
            end
            for (int i = 0; i < 8; i++) begin
                if (old[i].busy) begin
                    r = snoop(v, old[i].jp, old[i].jt, old[i].jv);
                    m[i].jp = r[32]; m[i].jv = r[31:0];
                    r = snoop(v, old[i].kp, old[i].kt, old[i].kv);
                    m[i].kp = r[32]; m[i].kv = r[31:0];
                end
            end
            if (sel >= 0) begin
                mCal = 1; mA = old[sel].jv; mB = old[sel].kv;
                mOp = old[sel].op; mDest = old[sel].dest;
                m[sel].busy = 1'b0;
            end else begin
                mCal = 0;
            end
            if (v.vld[0] && used < 8) begin
                m[freeSlot].busy = 1'b1;
                m[freeSlot].op   = v.op[3:0];
                m[freeSlot].jt   = v.qj[3:0];
                m[freeSlot].kt   = v.qk[3:0];
                m[freeSlot].dest = v.dest[3:0];
                r = snoop(v, v.qjb[0], v.qj[3:0], v.vj);
                m[freeSlot].jp = r[32]; m[freeSlot].jv = r[31:0];
                r = snoop(v, v.qkb[0], v.qk[3:0], v.vk);
                m[freeSlot].kp = r[32]; m[freeSlot].kv = r[31:0];
            end
        end
    endtask

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        //             rst rdy clr vld op  qjb qj vj      qkb qk vk      dest c0v c0t c0d     c1v c1t c1d      cal a       b      op dest full
        vecs.push_back('{1, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 5,      0, 0, 7,      3,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 5,      7,     0, 3, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 5,      7,     0, 3, 0});
        // SUB waiting on tag 6, woken by cdb1 two cycles after dispatch
        vecs.push_back('{0, 1, 0, 1, 1,  1, 6, 0,      0, 0, 1,      4,   0, 0, 0,       0, 0, 0,       0, 5,      7,     0, 3, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 5,      7,     0, 3, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       1, 6, 'h10,    0, 5,      7,     0, 3, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 'h10,   1,     1, 4, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 'h10,   1,     1, 4, 0});
        // dispatch-time forwarding from cdb0
        vecs.push_back('{0, 1, 0, 1, 2,  1, 2, 0,      0, 0, 3,      5,   1, 2, 9,       0, 0, 0,       0, 'h10,   1,     1, 4, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 9,      3,     2, 5, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 9,      3,     2, 5, 0});
        // fill all eight entries, each waiting on tag 8+i
        for (int i = 0; i < 8; i++)
            vecs.push_back('{0, 1, 0, 1, 0, 1, 32'(8 + i), 0, 0, 0, 32'(i), 32'(i),
                             0, 0, 0, 0, 0, 0, 0, 9, 3, 2, 5, (i == 7) ? 1 : 0});
        // ninth dispatch is dropped, then tag 11 frees entry 3
        vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 'hAA,   0, 0, 'hBB,   15,  0, 0, 0,       0, 0, 0,       0, 9,      3,     2, 5, 1});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   1, 11, 'h33,   0, 0, 0,       0, 9,      3,     2, 5, 1});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 'h33,   3,     0, 3, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 'h33,   3,     0, 3, 0});
        // wake entries 1,4 then 6 -> issue 1,4,6 back to back
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   1, 9, 'h100,   1, 12, 'h400,  0, 'h33,   3,     0, 3, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   1, 14, 'h600,  0, 0, 0,       1, 'h100,  1,     0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 'h400,  4,     0, 4, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 'h600,  6,     0, 6, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 'h600,  6,     0, 6, 0});
        // flush, then old tags must not wake anything
        vecs.push_back('{0, 1, 1, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   1, 8, 1,       1, 10, 2,      0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   1, 13, 3,      1, 15, 4,      0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        // stall: ready entry waits, stalled dispatch and stalled clear ignored
        vecs.push_back('{0, 1, 0, 1, 3,  0, 0, 'h11,   0, 0, 'h22,   7,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 4,  0, 0, 'h55,   0, 0, 'h66,   9,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 'h11,   'h22,  3, 7, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 'h11,   'h22,  3, 7, 0});
        // reset while a wakeup is on the bus
        vecs.push_back('{0, 1, 0, 1, 5,  1, 1, 0,      0, 0, 2,      2,   0, 0, 0,       0, 0, 0,       0, 'h11,   'h22,  3, 7, 0});
        vecs.push_back('{1, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   1, 1, 5,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        // both operands wake in one cycle from different buses
        vecs.push_back('{0, 1, 0, 1, 6,  1, 3, 0,      1, 4, 0,      8,   0, 0, 0,       0, 0, 0,       0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   1, 4, 'h44,    1, 3, 'h33,    0, 0,      0,     0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 'h33,   'h44,  6, 8, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 'h33,   'h44,  6, 8, 0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk_in);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].eCal[0], vecs[i].eA, vecs[i].eB,
                        vecs[i].eOp[3:0], vecs[i].eDest[3:0], vecs[i].eFull[0]);
        end

        // Randomized run against the reference model, starting from reset
        for (int n = 0; n < 3000; n++) begin
            v = '{default: 0};
            v.rst = (n == 0 || $urandom_range(0, 299) == 0) ? 1 : 0;
            v.rdy = ($urandom_range(0, 9) != 0) ? 1 : 0;
            v.clr = ($urandom_range(0, 149) == 0) ? 1 : 0;
            v.vld = $urandom_range(0, 1);
            v.op  = $urandom_range(0, 9);
            v.qjb = $urandom_range(0, 1);
            v.qj  = $urandom_range(0, 15);
            v.vj  = $urandom;
            v.qkb = $urandom_range(0, 1);
            v.qk  = $urandom_range(0, 15);
            v.vk  = $urandom;
            v.dest = $urandom_range(0, 15);
            if (v.rdy[0]) begin
                v.c0v = ($urandom_range(0, 9) < 6) ? 1 : 0;
                v.c0t = $urandom_range(0, 15);
                v.c0d = $urandom;
                v.c1v = ($urandom_range(0, 9) < 6) ? 1 : 0;
                v.c1t = $urandom_range(0, 15);
                v.c1d = $urandom;
                if (v.c0v[0] && v.c1v[0] && v.c0t == v.c1t) v.c1v = 0;
            end
            applyStimulus(v);
            modelStep(v);
            @(posedge clk_in);
            #1;
            checkOutput($sformatf("rand%0d", n), mCal, mA, mB, mOp, mDest, modelFull());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
